// File: rtl/cmd_frame_writer.sv
// cmd_frame_writer
// ----------------
// Writer side of the host command byte stream. It takes one command request
// per cmd_valid/cmd_ready handshake and serialises it into the 8-bit fifo
// write port in controller wire order: cmd byte, then arg msb, then arg lsb.
// Only the two argument-carrying codes (ARG_CMD_0 / ARG_CMD_1) produce the
// two argument bytes. Every other code is sent as a 1-byte frame.
//
// Optional feature macro: CMD_FRAME_WRITER_STATS_EN
//   When defined, the module adds the STAT_WIDTH parameter and the
//   frame_count output. frame_count counts completed frames and wraps.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   cmd_valid    request valid
//   cmd_ready    writer can accept a request this cycle (S_IDLE only)
//   cmd_in       command code
//   arg_in       16-bit argument (msb is byte 1, lsb is byte 2)
//   wdata        fifo write data
//   winc         fifo write strobe, one byte per high cycle
//   wfull        fifo full, active high
//   busy         frame in progress
//   frame_count  completed frames (only with CMD_FRAME_WRITER_STATS_EN)

module cmd_frame_writer #(
    parameter logic [7:0] ARG_CMD_0 = 8'h10,
    parameter logic [7:0] ARG_CMD_1 = 8'h11
`ifdef CMD_FRAME_WRITER_STATS_EN
    ,
    parameter int STAT_WIDTH = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_in,
    input  logic [15:0] arg_in,
    output logic [7:0]  wdata,
    output logic        winc,
    input  logic        wfull,
    output logic        busy
`ifdef CMD_FRAME_WRITER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] frame_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_MSB,
        S_LSB
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cmd_q;
    logic [15:0] arg_q;
    logic        has_arg;
    logic        accept;
    logic        last_byte;

    assign accept = cmd_valid && cmd_ready;

    // The final byte is the lsb of a 3-byte frame or the cmd of a 1-byte frame.
    // It only counts as written on a cycle where winc is high.
    assign last_byte = winc && ((state == S_LSB) || ((state == S_CMD) && !has_arg));

    // State register and request latches. The latches are written only on
    // accept, so input changes during a frame cannot disturb the bytes in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cmd_q   <= 8'h00;
            arg_q   <= 16'h0000;
            has_arg <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cmd_q   <= cmd_in;
                arg_q   <= arg_in;
                has_arg <= (cmd_in == ARG_CMD_0) || (cmd_in == ARG_CMD_1);
            end
        end
    end

    // Next state and outputs. winc is derived from the registered state, so a
    // reset drops it immediately. wfull holds the state, which keeps wdata
    // stable, so a stalled byte is retried and never duplicated.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        winc       = 1'b0;
        wdata      = cmd_q;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = S_CMD;
                end
            end
            S_CMD: begin
                winc  = !wfull;
                wdata = cmd_q;
                if (!wfull) begin
                    state_next = has_arg ? S_MSB : S_IDLE;
                end
            end
            S_MSB: begin
                winc  = !wfull;
                wdata = arg_q[15:8];
                if (!wfull) begin
                    state_next = S_LSB;
                end
            end
            S_LSB: begin
                winc  = !wfull;
                wdata = arg_q[7:0];
                if (!wfull) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef CMD_FRAME_WRITER_STATS_EN
    // Completed-frame counter. It wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (last_byte) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`else
    logic unused_last_byte;
    assign unused_last_byte = last_byte;
`endif

endmodule

// File: tb/tb_cmd_frame_writer.sv
// tb_cmd_frame_writer
// -------------------
// Scoreboard bench for cmd_frame_writer. Each request pushes its expected
// bytes into a queue. A monitor pops one byte on every cycle where winc is
// high and compares it against wdata. Handshake, busy and stall behaviour
// are checked directly with checkOutput.
// Build with CMD_FRAME_WRITER_STATS_EN to also check frame_count wrapping
// (STAT_WIDTH=4).

module tb_cmd_frame_writer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_in;
    logic [15:0] arg_in;
    logic [7:0]  wdata;
    logic        winc;
    logic        wfull;
    logic        busy;
`ifdef CMD_FRAME_WRITER_STATS_EN
    logic [3:0]  frame_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

`ifdef CMD_FRAME_WRITER_STATS_EN
    cmd_frame_writer #(.STAT_WIDTH(4)) dut (
`else
    cmd_frame_writer dut (
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_in     (cmd_in),
        .arg_in     (arg_in),
        .wdata      (wdata),
        .winc       (winc),
        .wfull      (wfull),
        .busy       (busy)
`ifdef CMD_FRAME_WRITER_STATS_EN
        ,
        .frame_count(frame_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte monitor: compare every written byte against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && winc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL byte_unexpected: got %02h, required no write", wdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (wdata !== e) begin
                    errors++;
                    $display("[TB] FAIL byte_order: got %02h, required %02h", wdata, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Present a request, push its expected bytes and wait for the accept edge.
    // Returns #1 after the accept edge, i.e. inside the first byte cycle.
    task automatic applyStimulus(input logic [7:0] c, input logic [15:0] a,
                                 input bit keep_valid);
        bit accepted;
        int budget;
        cmd_valid = 1'b1;
        cmd_in    = c;
        arg_in    = a;
        exp_q.push_back(c);
        if (c == 8'h10 || c == 8'h11) begin
            exp_q.push_back(a[15:8]);
            exp_q.push_back(a[7:0]);
        end
        budget = 0;
        do begin
            accepted = cmd_ready;
            step();
            budget++;
        end while (!accepted && budget < 50);
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got cmd_ready=0, required 1");
        end
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_in    = 8'h00;
        arg_in    = 16'h0000;
        wfull     = 1'b0;
        #12;
        checkOutput("reset_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        checkOutput("reset_busy", {15'd0, busy}, 16'd0);
        checkOutput("reset_winc", {15'd0, winc}, 16'd0);
        checkOutput("reset_wdata", {8'd0, wdata}, 16'h00);
        rst_n = 1'b1;
        step();

        // 1-byte frame
        applyStimulus(8'h01, 16'hFFFF, 1'b0);
        checkOutput("one_byte_winc", {15'd0, winc}, 16'd1);
        checkOutput("one_byte_ready", {15'd0, cmd_ready}, 16'd0);
        step();
        checkOutput("one_byte_ready_back", {15'd0, cmd_ready}, 16'd1);
        checkOutput("one_byte_busy_off", {15'd0, busy}, 16'd0);
        checkOutput("one_byte_winc_off", {15'd0, winc}, 16'd0);

        // 3-byte frame
        applyStimulus(8'h10, 16'h0242, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("three_byte_busy", {15'd0, busy}, 16'd1);
            checkOutput("three_byte_winc", {15'd0, winc}, 16'd1);
            step();
        end
        checkOutput("three_byte_busy_off", {15'd0, busy}, 16'd0);

        // wfull stall on the msb byte
        applyStimulus(8'h11, 16'hA5C3, 1'b0);
        checkOutput("stall_cmd_winc", {15'd0, winc}, 16'd1);
        step();
        wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall_winc", {15'd0, winc}, 16'd0);
            checkOutput("stall_wdata", {8'd0, wdata}, 16'h00A5);
            step();
        end
        wfull = 1'b0;
        #1;
        checkOutput("stall_release_winc", {15'd0, winc}, 16'd1);
        step();
        checkOutput("stall_lsb_winc", {15'd0, winc}, 16'd1);
        step();
        checkOutput("stall_done_ready", {15'd0, cmd_ready}, 16'd1);

        // Back-to-back requests with cmd_valid held high
        applyStimulus(8'h10, 16'h1234, 1'b1);
        cmd_in = 8'h03;
        arg_in = 16'hFFFF;
        exp_q.push_back(8'h03);
        for (int i = 0; i < 3; i++) begin
            checkOutput("b2b_frame_winc", {15'd0, winc}, 16'd1);
            step();
        end
        checkOutput("b2b_idle_ready", {15'd0, cmd_ready}, 16'd1);
        checkOutput("b2b_idle_winc", {15'd0, winc}, 16'd0);
        step();
        cmd_valid = 1'b0;
        checkOutput("b2b_second_winc", {15'd0, winc}, 16'd1);
        checkOutput("b2b_second_busy", {15'd0, busy}, 16'd1);
        step();
        checkOutput("b2b_done_busy", {15'd0, busy}, 16'd0);

        // Reset mid-frame, after the msb byte was written
        applyStimulus(8'h10, 16'hBEEF, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_winc", {15'd0, winc}, 16'd0);
        checkOutput("midreset_ready", {15'd0, cmd_ready}, 16'd1);
        checkOutput("midreset_leftover", exp_q.size(), 16'd1);
        exp_q.delete();
        rst_n = 1'b1;
        step();
        applyStimulus(8'h11, 16'h0102, 1'b0);
        checkOutput("post_reset_winc", {15'd0, winc}, 16'd1);
        checkOutput("post_reset_wdata", {8'd0, wdata}, 16'h0011);
        step();
        step();
        step();

        // 17 more 1-byte frames: 18 frames since reset
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'h20 + 8'(i), 16'h0000, 1'b0);
            step();
        end
`ifdef CMD_FRAME_WRITER_STATS_EN
        checkOutput("frame_count_wrap", {12'd0, frame_count}, 16'd2);
`endif

        step();
        checkOutput("scoreboard_empty", exp_q.size(), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
